// File: rtl/lab1_pkg.sv
// Shared types and sizes for the Lab1 gate-block vector sequencer.
package lab1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;

endpackage

// File: rtl/lab1_golden.sv
// Reference gate model: expected Lab1_hello responses for one input vector.
module lab1_golden (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic and_exp,
  output logic or_exp,
  output logic nand_exp,
  output logic nor_exp,
  output logic not_a_exp
);

  assign and_exp   = a & b & c;
  assign or_exp    = a | b | c;
  assign nand_exp  = ~(a & b & c);
  assign nor_exp   = ~(a | b | c);
  assign not_a_exp = ~a;

endmodule

// File: rtl/lab1_vec_seq.sv
// Walks all 8 input vectors into the Lab1_hello gate block, holding each for
// HOLD_CYCLES cycles, and scores the responses against lab1_golden.
module lab1_vec_seq
  import lab1_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       tb_a,
  output logic       tb_b,
  output logic       tb_c,
  input  logic       L1_andOut,
  input  logic       L1_orOut,
  input  logic       L1_nandOut,
  input  logic       L1_norOut,
  input  logic       L1_notOut_a,
  output logic [3:0] err_cnt,
  output logic [7:0] err_vec,
  output logic       pass
);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] idx;
  logic [3:0]       hold;
  logic             cmp, last_cmp, mismatch;
  logic             and_exp, or_exp, nand_exp, nor_exp, not_a_exp;

  lab1_golden u_golden (
    .a         (tb_a),
    .b         (tb_b),
    .c         (tb_c),
    .and_exp   (and_exp),
    .or_exp    (or_exp),
    .nand_exp  (nand_exp),
    .nor_exp   (nor_exp),
    .not_a_exp (not_a_exp)
  );

  // Stimulus registers lag idx by one cycle; hold>=1 on the compare cycle,
  // so the gate block already sees the current vector when it is scored.
  assign cmp      = (state == DRIVE) && (hold == 4'(HOLD_CYCLES - 1));
  assign last_cmp = cmp && (idx == VEC_W'(NUM_VEC - 1));
  assign mismatch = {L1_andOut, L1_orOut, L1_nandOut, L1_norOut, L1_notOut_a}
                 != {and_exp, or_exp, nand_exp, nor_exp, not_a_exp};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (last_cmp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      hold    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tb_a    <= 1'b0;
      tb_b    <= 1'b0;
      tb_c    <= 1'b0;
      err_cnt <= '0;
      err_vec <= '0;
      pass    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state == DRIVE);
      done  <= (state == DONE);
      {tb_a, tb_b, tb_c} <= (state == DRIVE) ? idx : '0;

      case (state)
        IDLE: begin
          if (start) begin
            idx     <= '0;
            hold    <= '0;
            err_cnt <= '0;
            err_vec <= '0;
            pass    <= 1'b0;
          end
        end
        DRIVE: begin
          if (cmp) begin
            hold <= '0;
            idx  <= idx + 1'b1;
            if (mismatch) begin
              err_cnt      <= err_cnt + 4'd1;
              err_vec[idx] <= 1'b1;
            end
          end else begin
            hold <= hold + 4'd1;
          end
        end
        DONE:    pass <= (err_cnt == 4'd0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lab1_vec_seq.sv
// Self-checking bench for lab1_vec_seq: fault-injected gate models, per-cycle
// sequence checks, mid-run reset and back-to-back runs at HOLD_CYCLES=2.
module tb_lab1_vec_seq;

  typedef struct packed {
    logic [3:0] cnt;
    logic [7:0] vec;
    logic       pass;
  } res_t;

  typedef struct {
    int   fault;
    bit   repulse;
    res_t ex;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, start, start2;
  logic       tb_a, tb_b, tb_c, busy, done, pass;
  logic [3:0] err_cnt;
  logic [7:0] err_vec;
  logic       and_o, or_o, nand_o, nor_o, nota_o;
  logic       tb_a2, tb_b2, tb_c2, busy2, done2, pass2;
  logic [3:0] err_cnt2;
  logic [7:0] err_vec2;
  int         fault = 0;
  int         checks = 0;
  int         errors = 0;
  res_t       sb[$];
  vec_t       tbl[7];

  always #5 clk = ~clk;

  // Gate-block model with selectable faults.
  always_comb begin
    and_o  = tb_a & tb_b & tb_c;
    or_o   = tb_a | tb_b | tb_c;
    nand_o = ~(tb_a & tb_b & tb_c);
    nor_o  = ~(tb_a | tb_b | tb_c);
    nota_o = ~tb_a;
    case (fault)
      1: and_o  = 1'b0;
      2: nota_o = tb_a;
      3: nand_o = 1'b1;
      4: begin
        and_o  = ~(tb_a & tb_b & tb_c);
        or_o   = ~(tb_a | tb_b | tb_c);
        nand_o = tb_a & tb_b & tb_c;
        nor_o  = tb_a | tb_b | tb_c;
        nota_o = tb_a;
      end
      5: nor_o  = 1'b0;
      default: ;
    endcase
  end

  lab1_vec_seq #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .tb_a(tb_a), .tb_b(tb_b), .tb_c(tb_c),
    .L1_andOut(and_o), .L1_orOut(or_o), .L1_nandOut(nand_o),
    .L1_norOut(nor_o), .L1_notOut_a(nota_o),
    .err_cnt(err_cnt), .err_vec(err_vec), .pass(pass)
  );

  lab1_vec_seq #(.HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .tb_a(tb_a2), .tb_b(tb_b2), .tb_c(tb_c2),
    .L1_andOut(tb_a2 & tb_b2 & tb_c2), .L1_orOut(tb_a2 | tb_b2 | tb_c2),
    .L1_nandOut(~(tb_a2 & tb_b2 & tb_c2)), .L1_norOut(~(tb_a2 | tb_b2 | tb_c2)),
    .L1_notOut_a(~tb_a2),
    .err_cnt(err_cnt2), .err_vec(err_vec2), .pass(pass2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Full HOLD_CYCLES=4 run: edge 0 accepts start, done is seen after edge 33.
  task automatic run_vec(input int f, input bit rep, input res_t ex);
    res_t       want;
    logic [2:0] es;
    fault = f;
    @(negedge clk);
    start = 1'b1;
    sb.push_back(ex);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      es = (k <= 32) ? 3'((k - 1) / 4) : 3'd0;
      chk($sformatf("seq_f%0d_k%0d", f, k), {27'd0, tb_a, tb_b, tb_c, busy, done},
          {27'd0, es, (k <= 32), (k == 33)});
      if (k == 2) chk("cleared_on_start", {19'd0, err_cnt, err_vec, pass}, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: actual done=1 required no done");
        end else begin
          want = sb.pop_front();
          chk($sformatf("result_f%0d", f), {19'd0, err_cnt, err_vec, pass}, {19'd0, want});
        end
      end
      if (k == 34) chk("result_hold", {19'd0, err_cnt, err_vec, pass}, {19'd0, ex});
      start = rep && (k == 5 || k == 20);
    end
  endtask

  initial begin
    int   last, first, n;
    logic d1, d2;

    tbl[0] = '{0, 1'b0, '{4'd0, 8'h00, 1'b1}};
    tbl[1] = '{1, 1'b0, '{4'd1, 8'h80, 1'b0}};
    tbl[2] = '{2, 1'b0, '{4'd8, 8'hFF, 1'b0}};
    tbl[3] = '{0, 1'b1, '{4'd0, 8'h00, 1'b1}};
    tbl[4] = '{3, 1'b0, '{4'd1, 8'h80, 1'b0}};
    tbl[5] = '{4, 1'b0, '{4'd8, 8'hFF, 1'b0}};
    tbl[6] = '{5, 1'b0, '{4'd1, 8'h01, 1'b0}};

    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    #2;
    chk("reset_state", {19'd0, tb_a, tb_b, tb_c, busy, done, err_cnt, err_vec, pass}, 32'd0);
    chk("reset_state2", {19'd0, tb_a2, tb_b2, tb_c2, busy2, done2, err_cnt2, err_vec2, pass2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i].fault, tbl[i].repulse, tbl[i].ex);

    // Mid-run reset with every output wrong, so the error count is nonzero first.
    fault = 4;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("pre_reset_err_cnt", {28'd0, err_cnt}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {19'd0, tb_a, tb_b, tb_c, busy, done, err_cnt, err_vec, pass}, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1 chk("in_reset", {30'd0, busy, done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 chk($sformatf("idle_after_reset_%0d", k), {30'd0, busy, done}, 32'd0);
    end
    run_vec(0, 1'b0, '{4'd0, 8'h00, 1'b1});

    // Back-to-back runs at HOLD_CYCLES=2 with start held high.
    @(negedge clk);
    start2 = 1'b1;
    last   = -1;
    first  = -1;
    n      = 0;
    d1     = 1'b0;
    d2     = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (d1) chk("b2b_idle_gap", {31'd0, busy2}, 32'd0);
      if (d2) chk("b2b_next_drive", {31'd0, busy2}, 32'd1);
      d2 = d1;
      d1 = done2;
      if (done2) begin
        n++;
        if (last >= 0) chk("b2b_period", c - last, 32'd18);
        else first = c;
        last = c;
        chk("b2b_result", {19'd0, err_cnt2, err_vec2, pass2}, {19'd0, 4'd0, 8'h00, 1'b1});
      end
    end
    chk("b2b_first_done", first, 32'd17);
    chk("b2b_runs", n, 32'd3);
    start2 = 1'b0;
    repeat (30) @(posedge clk);
    #1 chk("b2b_stops", {30'd0, busy2, done2}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab1_vec_seq.md
LAB1_VEC_SEQ -- requirements
Module: lab1_vec_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, number of clock cycles each input vector is held (legal range 2..15).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  run request, sampled on rising clk.
REQ-005 SHALL have port busy  output  1  high while a run is in progress.
REQ-006 SHALL have port done  output  1  one-cycle pulse at run completion.
REQ-007 SHALL have ports tb_a, tb_b, tb_c  output  1 each  stimulus driven into the Lab1_hello gate block.
REQ-008 SHALL have ports L1_andOut, L1_orOut, L1_nandOut, L1_norOut, L1_notOut_a  input  1 each  gate-block responses.
REQ-009 SHALL have port err_cnt  output  4  number of failing vectors in the last run (0..8).
REQ-010 SHALL have port err_vec  output  8  bit i set if vector i failed.
REQ-011 SHALL have port pass  output  1  high when the last completed run had err_cnt==0.

Function
REQ-012 SHALL implement FSM states IDLE, DRIVE, DONE.
REQ-013 IDLE: tb_a/tb_b/tb_c SHALL be 0 and busy 0; start==1 SHALL move to DRIVE with idx=0, hold=0, and clear err_cnt, err_vec and pass.
REQ-014 DRIVE: {tb_a,tb_b,tb_c} SHALL equal 3-bit idx (tb_a = MSB); busy SHALL be 1.
REQ-015 hold SHALL increment every DRIVE cycle; at hold==HOLD_CYCLES-1 the five responses SHALL be compared with the expected values, then hold resets to 0 and idx increments.
REQ-016 Expected values: and=a&b&c, or=a|b|c, nand=~(a&b&c), nor=~(a|b|c), not_a=~a.
REQ-017 Any mismatch on a compare cycle SHALL increment err_cnt by 1 and set err_vec[idx] in the following cycle; multiple mismatching outputs on one vector count once.
REQ-018 After the compare for idx==7, SHALL enter DONE (no idx wrap into a second pass).
REQ-019 DONE: SHALL last exactly 1 cycle with done=1, busy=0, stimulus 0, pass = (err_cnt==0), then return to IDLE.
REQ-020 Latency: with start accepted at edge 0, done SHALL be high during the cycle following edge 8*HOLD_CYCLES+1.
REQ-021 start while in DRIVE SHALL be ignored; start in DONE SHALL be ignored (the next accepted start is in IDLE).
REQ-022 err_cnt, err_vec and pass SHALL hold their values from DONE until the next accepted start.
REQ-023 Outputs SHALL be registered; responses SHALL be sampled only on compare cycles.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, idx=0, hold=0, busy=0, done=0, tb_a=tb_b=tb_c=0, err_cnt=0, err_vec=0, pass=0, independent of clk.
REQ-025 Reset asserted mid-run SHALL abort the run with no done pulse; after release the block SHALL wait in IDLE for start.
REQ-026 Release of rst_n SHALL take effect at the first rising clk edge at which it is high.

Structure
REQ-027 Package lab1_pkg SHALL hold the state enum (IDLE, DRIVE, DONE), NUM_VEC=8 and VEC_W=3.
REQ-028 The expected-value logic SHALL be one combinational sub-module lab1_golden (inputs a,b,c; five expected outputs), instantiated once.
REQ-029 All other logic (FSM, counters, scoreboard) SHALL reside in lab1_vec_seq.

Verification
REQ-030 Correct Lab1_hello, HOLD_CYCLES=4, start pulse -> stimulus 000..111, 4 cycles each; done at cycle 34; err_cnt=0, err_vec=8'h00, pass=1.
REQ-031 L1_andOut stuck-at-0 model -> only vector 7 fails: err_cnt=1, err_vec=8'h80, pass=0.
REQ-032 L1_notOut_a tied to tb_a (inverter missing) -> all vectors fail: err_cnt=8, err_vec=8'hFF, pass=0.
REQ-033 start re-pulsed at cycles 5 and 20 of a run -> ignored; done still at cycle 34, single run.
REQ-034 rst_n pulled low at cycle 13 mid-run -> all outputs 0 immediately; no done; a new start after release gives a full clean run.
REQ-035 HOLD_CYCLES=2, start held high continuously -> runs back-to-back with one IDLE cycle between done and the next DRIVE; done every 18 cycles.
